prog_uploader: RTL and testbench
================================

PROG_UPLOADER -- requirements
Module: prog_uploader

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning UART bit rate.
REQ-003 The block SHALL have parameter ADDR_W, default 14, meaning instruction-memory word-address width.
REQ-004 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_i  input  1  UART serial input, idle high, asynchronous to clk.
REQ-007 The block SHALL have port start_i  input  1  single-cycle pulse arming an upload.
REQ-008 The block SHALL have port upg_active_o  output  1  high from accepted start_i until upload ends, selecting the memory write path.
REQ-009 The block SHALL have port upg_wen_o  output  1  single-cycle instruction-memory write strobe.
REQ-010 The block SHALL have port upg_adr_o  output  ADDR_W  word address, valid while upg_wen_o is high.
REQ-011 The block SHALL have port upg_dat_o  output  32  instruction word, valid while upg_wen_o is high.
REQ-012 The block SHALL have port upg_done_o  output  1  high after a successful upload, held until the next accepted start_i.
REQ-013 The block SHALL have port upg_err_o  output  1  sticky error flag, cleared only by the next accepted start_i or reset.

Function
REQ-014 The UART receiver SHALL double-flop rx_i, use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), accept 8N1, LSB first.
REQ-015 A start bit SHALL be accepted only if rx remains low at CLKS_PER_BIT/2; otherwise the receiver returns to idle and emits no byte.
REQ-016 Data and stop bits SHALL be sampled at mid-bit; a valid byte strobe SHALL last one cycle at the stop-bit sample.
REQ-017 A stop bit sampled low SHALL discard the byte and set upg_err_o.
REQ-018 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHK (macro only), DONE.
REQ-019 In IDLE, DONE, or with upg_err_o set, start_i SHALL clear upg_done_o, upg_err_o, and the word/byte counters, set upg_active_o, and enter LEN_LO; start_i in any other state SHALL be ignored.
REQ-020 LEN_LO and LEN_HI SHALL capture a 16-bit little-endian word count N.
REQ-021 N = 0 SHALL go directly to DONE with no write; N > 2^ADDR_W SHALL set upg_err_o, clear upg_active_o, and go to IDLE.
REQ-022 DATA SHALL assemble 4 bytes little-endian per word; upg_wen_o SHALL pulse the cycle after the 4th byte strobe, with upg_adr_o = word index (0..N-1).
REQ-023 After the N-th write the FSM SHALL enter DONE (or CHK), and on entering DONE set upg_done_o and clear upg_active_o.
REQ-024 Bytes received in IDLE or DONE SHALL be ignored.
REQ-025 Word index SHALL never wrap; REQ-021 guarantees index < 2^ADDR_W.

Reset
REQ-026 Asserting rstn low at any time SHALL force state IDLE, receiver idle, and all outputs to 0, abandoning a partial word without a write.

Configuration
REQ-027 With UPG_CHECKSUM_EN defined, after the last data byte the FSM SHALL enter CHK, receive one byte, and compare it to the XOR of all length and data bytes; on match go to DONE, on mismatch set upg_err_o, clear upg_active_o, and return to IDLE.
REQ-028 Without UPG_CHECKSUM_EN, CHK and the XOR register SHALL not exist and DATA SHALL go directly to DONE.

Structure
REQ-029 State encoding, the byte-framing constants, and the CLKS_PER_BIT function SHALL live in shared package upg_pkg.
REQ-030 The serial receiver SHALL be sub-module uart_rx_byte (outputs: byte[7:0], byte_valid, frame_err).

Verification (CLK_FREQ=1000, BAUD=100, ADDR_W=14)
REQ-031 start_i, then bytes 02 00 13 00 00 00 6F 00 00 00 -> writes adr0=0x00000013 and adr1=0x0000006F, then upg_done_o=1 and upg_active_o=0.
REQ-032 start_i, then bytes 00 00 -> upg_done_o=1 with no upg_wen_o pulse.
REQ-033 start_i, then length 01 41 (N=16641) -> upg_err_o=1, state IDLE, no write.
REQ-034 A 3-clock rx glitch low produces no byte; a byte with stop bit 0 sets upg_err_o.
REQ-035 rstn pulsed low after 2 data bytes -> all outputs 0, no write; the next full upload succeeds.
REQ-036 With UPG_CHECKSUM_EN: 01 00 13 00 00 00 12 -> done; checksum 0x00 instead -> upg_err_o=1.

Source files
------------

// File: rtl/prog_uploader_pkg.sv
// Shared state encodings, byte-framing constants and baud helper for the program uploader.
// UPG_CHECKSUM_EN adds the CHK state used for the trailing XOR checksum byte.
package upg_pkg;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef UPG_CHECKSUM_EN
    CHK,
`endif
    DONE
  } upg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/prog_uploader_if.sv
// Instruction-memory write bus and status flags driven by the program uploader.
// The master side belongs to the uploader, the slave side to the memory/CPU wrapper.
interface prog_uploader_if #(
  parameter int ADDR_W = 14
);

  logic              upg_active_o;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              upg_err_o;

  modport master (
    output upg_active_o,
    output upg_wen_o,
    output upg_adr_o,
    output upg_dat_o,
    output upg_done_o,
    output upg_err_o
  );

  modport slave (
    input upg_active_o,
    input upg_wen_o,
    input upg_adr_o,
    input upg_dat_o,
    input upg_done_o,
    input upg_err_o
  );

endinterface

// File: rtl/prog_uploader_uart_rx.sv
// 8N1 UART byte receiver with mid-bit sampling, start-bit validation and stop-bit framing check.
// byte_valid / frame_err are single-cycle strobes at the stop-bit sample.
module uart_rx_byte
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             rx_meta, rx_sync, rx_prev;

  // Two flops tame metastability; the third lets a start bit begin only on a falling edge,
  // so a line held low after a framing error cannot retrigger the receiver.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {rx_meta, rx_sync, rx_prev} <= 3'b111;
    end else begin
      {rx_meta, rx_sync, rx_prev} <= {rx_i, rx_meta, rx_sync};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        if (rx_prev && !rx_sync) state_nx = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx     = '0;
          shreg_nx   = {rx_sync, shreg[7:1]};
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          state_nx = RX_IDLE;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  assign rx_byte    = shreg;
  assign byte_valid = (state == RX_STOP) && (cnt == FULL_M1) && rx_sync;
  assign frame_err  = (state == RX_STOP) && (cnt == FULL_M1) && !rx_sync;

endmodule

// File: rtl/prog_uploader.sv
// Program uploader: receives a length-prefixed little-endian word stream over UART and writes it
// into instruction memory. Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_uploader
  import upg_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 14
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_i,
  input  logic            start_i,
  prog_uploader_if.master upg
);

  localparam int          CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, frame_err;

  upg_state_e        state, state_nx;
  logic [7:0]        len_lo, len_lo_nx;
  logic [15:0]       len, len_nx;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   word_idx, word_idx_nx;
  logic [1:0]        byte_cnt, byte_cnt_nx;
  logic [23:0]       word_sr, word_sr_nx;
  logic              active_q, active_nx;
  logic              wen_q, wen_nx;
  logic              done_q, done_nx;
  logic              err_q, err_nx;
  logic [ADDR_W-1:0] adr_q, adr_nx;
  logic [31:0]       dat_q, dat_nx;
  logic              start_ok, last_written;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]        csum, csum_nx;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx_i       (rx_i),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign n_words  = {rx_byte, len_lo};
  assign start_ok = start_i && ((state == IDLE) || (state == DONE) || err_q);
  // DATA is left only in the cycle the final strobe is out, so active still covers that write.
  assign last_written = (state == DATA) && wen_q && (32'(word_idx) == 32'(len));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      len_lo   <= '0;
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_sr  <= '0;
      active_q <= 1'b0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
`ifdef UPG_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_nx;
      len_lo   <= len_lo_nx;
      len      <= len_nx;
      word_idx <= word_idx_nx;
      byte_cnt <= byte_cnt_nx;
      word_sr  <= word_sr_nx;
      active_q <= active_nx;
      wen_q    <= wen_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
      adr_q    <= adr_nx;
      dat_q    <= dat_nx;
`ifdef UPG_CHECKSUM_EN
      csum     <= csum_nx;
`endif
    end
  end

  // A framing error aborts any upload in progress; in IDLE/DONE it only raises the flag.
  always_comb begin
    state_nx    = state;
    len_lo_nx   = len_lo;
    len_nx      = len;
    word_idx_nx = word_idx;
    byte_cnt_nx = byte_cnt;
    word_sr_nx  = word_sr;
    active_nx   = active_q;
    wen_nx      = 1'b0;
    done_nx     = done_q;
    err_nx      = err_q;
    adr_nx      = adr_q;
    dat_nx      = dat_q;
`ifdef UPG_CHECKSUM_EN
    csum_nx     = csum;
`endif
    if (start_ok) begin
      state_nx    = LEN_LO;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      active_nx   = 1'b1;
      word_idx_nx = '0;
      byte_cnt_nx = '0;
`ifdef UPG_CHECKSUM_EN
      csum_nx     = '0;
`endif
    end else if (frame_err) begin
      err_nx = 1'b1;
      if ((state != IDLE) && (state != DONE)) begin
        state_nx  = IDLE;
        active_nx = 1'b0;
      end
    end else if (last_written) begin
`ifdef UPG_CHECKSUM_EN
      state_nx  = CHK;
`else
      state_nx  = DONE;
      done_nx   = 1'b1;
      active_nx = 1'b0;
`endif
    end else if (byte_valid) begin
      case (state)
        LEN_LO: begin
          len_lo_nx = rx_byte;
          state_nx  = LEN_HI;
`ifdef UPG_CHECKSUM_EN
          csum_nx   = rx_byte;
`endif
        end
        LEN_HI: begin
          len_nx = n_words;
`ifdef UPG_CHECKSUM_EN
          csum_nx = csum ^ rx_byte;
`endif
          if (n_words == 16'd0) begin
            state_nx  = DONE;
            done_nx   = 1'b1;
            active_nx = 1'b0;
          end else if (32'(n_words) > MAX_WORDS) begin
            state_nx  = IDLE;
            err_nx    = 1'b1;
            active_nx = 1'b0;
          end else begin
            state_nx  = DATA;
          end
        end
        DATA: begin
          byte_cnt_nx = byte_cnt + 1'b1;
`ifdef UPG_CHECKSUM_EN
          csum_nx     = csum ^ rx_byte;
`endif
          if (byte_cnt == LAST_BYTE) begin
            wen_nx      = 1'b1;
            adr_nx      = word_idx[ADDR_W-1:0];
            dat_nx      = {rx_byte, word_sr};
            word_idx_nx = word_idx + 1'b1;
          end else begin
            word_sr_nx  = {rx_byte, word_sr[23:8]};
          end
        end
`ifdef UPG_CHECKSUM_EN
        CHK: begin
          active_nx = 1'b0;
          if (rx_byte == csum) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
            err_nx   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign upg.upg_active_o = active_q;
  assign upg.upg_wen_o    = wen_q;
  assign upg.upg_adr_o    = adr_q;
  assign upg.upg_dat_o    = dat_q;
  assign upg.upg_done_o   = done_q;
  assign upg.upg_err_o    = err_q;

endmodule

// File: tb/tb_prog_uploader.sv
// Self-checking bench for prog_uploader: directed upload scenarios plus randomized uploads,
// checked against a byte-stream reference model. Works with and without UPG_CHECKSUM_EN.
module tb_prog_uploader;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int ADDR_W   = 14;
  localparam int CPB      = CLK_FREQ / BAUD;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic rx    = 1'b1;
  logic start = 1'b0;

  prog_uploader_if #(.ADDR_W(ADDR_W)) upg ();

  prog_uploader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_i    (rx),
    .start_i (start),
    .upg     (upg)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: tracks the bytes of the current upload and derives flags/writes from their position.
  bit          m_active, m_done, m_err;
  int          m_n;
  logic [7:0]  m_bytes[$];
  wr_t         exp_wr[$];
  bit          check_en = 1'b0;

  int                wr_seen = 0;
  logic [ADDR_W-1:0] last_adr;
  logic [31:0]       last_dat;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_n      = 0;
    m_bytes.delete();
    exp_wr.delete();
  endfunction

  function automatic void model_start();
    if (!m_active) begin
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_active = 1'b1;
      m_bytes.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    int  k;
    int  d;
    wr_t w;
    logic [7:0] x;
    if (!stop_ok) begin
      m_err    = 1'b1;
      m_active = 1'b0;
      return;
    end
    if (!m_active) return;
    m_bytes.push_back(b);
    k = m_bytes.size();
    if (k == 2) begin
      m_n = int'({m_bytes[1], m_bytes[0]});
      if (m_n == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else if (m_n > (1 << ADDR_W)) begin
        m_active = 1'b0;
        m_err    = 1'b1;
      end
    end else if (k > 2) begin
      d = k - 2;
      if ((d % 4 == 0) && (d <= 4 * m_n)) begin
        w.adr = ADDR_W'(d / 4 - 1);
        w.dat = {m_bytes[k-1], m_bytes[k-2], m_bytes[k-3], m_bytes[k-4]};
        exp_wr.push_back(w);
`ifndef UPG_CHECKSUM_EN
        if (d == 4 * m_n) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
`endif
      end
`ifdef UPG_CHECKSUM_EN
      if (d == 4 * m_n + 1) begin
        x = 8'h00;
        for (int i = 0; i < k - 1; i++) x ^= m_bytes[i];
        m_active = 1'b0;
        if (x == b) m_done = 1'b1;
        else        m_err  = 1'b1;
      end
`endif
    end
  endfunction

  // Compare process: every write strobe against the scoreboard, and the flags whenever the line is settled.
  always @(negedge clk) begin
    wr_t e;
    if (rstn && upg.upg_wen_o) begin
      wr_seen++;
      last_adr = upg.upg_adr_o;
      last_dat = upg.upg_dat_o;
      check_output("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        check_output("wr_adr", 32'(upg.upg_adr_o), 32'(e.adr));
        check_output("wr_dat", upg.upg_dat_o, e.dat);
      end
    end
    if (check_en) begin
      check_output("active", 32'(upg.upg_active_o), 32'(m_active));
      check_output("done",   32'(upg.upg_done_o),   32'(m_done));
      check_output("err",    32'(upg.upg_err_o),    32'(m_err));
    end
  end

  task automatic do_reset();
    check_en = 1'b0;
    rstn     = 1'b0;
    model_reset();
    @(negedge clk);
    check_output("rst_active", 32'(upg.upg_active_o), 32'd0);
    check_output("rst_wen",    32'(upg.upg_wen_o),    32'd0);
    check_output("rst_adr",    32'(upg.upg_adr_o),    32'd0);
    check_output("rst_dat",    upg.upg_dat_o,         32'd0);
    check_output("rst_done",   32'(upg.upg_done_o),   32'd0);
    check_output("rst_err",    32'(upg.upg_err_o),    32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic do_start();
    check_en = 1'b0;
    model_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    check_en = 1'b0;
    model_byte(b, stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    check_output("wr_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic send_upload(input logic [31:0] words[$], input bit bad_csum);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(words.size());
    x = n[7:0] ^ n[15:8];
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (words[i]) begin
      for (int j = 0; j < 4; j++) begin
        x ^= words[i][8*j +: 8];
        send_byte(words[i][8*j +: 8]);
      end
    end
`ifdef UPG_CHECKSUM_EN
    send_byte(bad_csum ? ~x : x);
`else
    if (bad_csum) send_byte(x);
`endif
  endtask

  task automatic run_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int n;
      int mode;
      logic [31:0] ws[$];
      ws.delete();
      n    = $urandom_range(0, 3);
      mode = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) ws.push_back($urandom());
      do_start();
      case (mode)
        0: begin
          send_byte(8'(n));
          send_byte(8'h00);
          send_byte(8'($urandom()));
          do_reset();
        end
        1: begin
          send_byte(8'(n));
          send_byte(8'($urandom()), 1'b0);
        end
        default: send_upload(ws, $urandom_range(0, 3) == 0);
      endcase
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom()));
    end
  endtask

  initial begin
    int w0;
    logic [31:0] ws[$];

    do_reset();

    // Two-word upload
    do_start();
    w0 = wr_seen;
    ws = '{32'h0000_0013, 32'h0000_006F};
    send_upload(ws, 1'b0);
    check_output("two_words_count", 32'(wr_seen - w0), 32'd2);
    check_output("two_words_adr",   32'(last_adr), 32'd1);
    check_output("two_words_dat",   last_dat, 32'h0000_006F);
    check_output("two_words_done",  32'(upg.upg_done_o), 32'd1);
    check_output("two_words_act",   32'(upg.upg_active_o), 32'd0);

    // Zero-length upload
    do_start();
    w0 = wr_seen;
    send_byte(8'h00);
    send_byte(8'h00);
    check_output("zero_len_done",   32'(upg.upg_done_o), 32'd1);
    check_output("zero_len_writes", 32'(wr_seen - w0), 32'd0);

    // Oversized length: 0x4101 = 16641 words
    do_start();
    w0 = wr_seen;
    send_byte(8'h01);
    send_byte(8'h41);
    check_output("too_long_err",    32'(upg.upg_err_o), 32'd1);
    check_output("too_long_act",    32'(upg.upg_active_o), 32'd0);
    check_output("too_long_writes", 32'(wr_seen - w0), 32'd0);

    // Short glitch low must not produce a byte; then a bad stop bit flags an error
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    do_start();
    send_byte(8'h55, 1'b0);
    check_output("frame_err", 32'(upg.upg_err_o), 32'd1);

    // Reset after a partial word, then a full upload
    do_start();
    w0 = wr_seen;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check_output("reset_no_write", 32'(wr_seen - w0), 32'd0);
    do_start();
    ws = '{32'hDEAD_BEEF, 32'h1234_5678};
    send_upload(ws, 1'b0);
    check_output("after_reset_writes", 32'(wr_seen - w0), 32'd2);
    check_output("after_reset_dat",    last_dat, 32'h1234_5678);
    check_output("after_reset_done",   32'(upg.upg_done_o), 32'd1);

    // start_i mid-upload is ignored
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    do_start();
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    check_output("restart_ignored_dat", last_dat, 32'h1234_5678);
    check_output("restart_ignored_adr", 32'(last_adr), 32'd0);

`ifdef UPG_CHECKSUM_EN
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h12);
    check_output("csum_ok_done", 32'(upg.upg_done_o), 32'd1);
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check_output("csum_bad_err", 32'(upg.upg_err_o), 32'd1);
`endif

    run_random(12);

    check_en = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: bench did not finish, vectors %0d, miscompares %0d", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
